// File: rtl/dsp_mac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dsp_mac_pkg
// Description : Shared types and constants for the DSP48A1 MAC controller.
// Revision    : 1.0 - initial release
// ============================================================================
package dsp_mac_pkg;

   localparam int DSP_LAT = 3;

   // OPMODE: X mux in [1:0], Z mux in [3:2]; pre-adder and subtract bits stay 0
   localparam logic [7:0] OPM_FIRST = 8'h01;
   localparam logic [7:0] OPM_ACC   = 8'h09;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage : dsp_mac_pkg
`default_nettype wire

// File: rtl/dsp_mac_vpipe.sv
`default_nettype none
// ============================================================================
// Module      : dsp_mac_vpipe
// Description : Beat-valid delay line and first-term flag aligned to the DSP
//               register stages.
// Revision    : 1.0 - initial release
// ============================================================================
module dsp_mac_vpipe #(
   parameter int DEPTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_vld,
   input  logic             i_first,
   output logic [DEPTH-1:0] o_vld,
   output logic             o_first
);

   logic [DEPTH-1:1] r_vld;
   logic             r_first;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld   <= '0;
         r_first <= 1'b0;
      end else begin
         r_vld[1] <= i_vld;
         for (int k = 2; k < DEPTH; k++) begin
            r_vld[k] <= r_vld[k-1];
         end
         r_first <= i_vld & i_first;
      end
   end

   // stage0 is the beat cycle itself, so it is passed through unregistered
   assign o_vld   = {r_vld, i_vld};
   assign o_first = r_first;

endmodule : dsp_mac_vpipe
`default_nettype wire

// File: rtl/dsp48a1_mac_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dsp48a1_mac_ctrl
// Description : Streams signed operand pairs into an external DSP48A1 and
//               returns the accumulated dot product.
// Revision    : 1.0 - initial release
// ============================================================================
module dsp48a1_mac_ctrl #(
   parameter int LEN_W   = 8,
   parameter int DSP_LAT = dsp_mac_pkg::DSP_LAT
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [17:0]      s_a,
   input  logic [17:0]      s_b,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [47:0]      m_result,
   output logic             m_carry,
   output logic [17:0]      dsp_a,
   output logic [17:0]      dsp_b,
   output logic [47:0]      dsp_c,
   output logic [17:0]      dsp_d,
   output logic             dsp_carryin,
   output logic [7:0]       dsp_opmode,
   output logic             dsp_cea,
   output logic             dsp_ceb,
   output logic             dsp_cem,
   output logic             dsp_cep,
   output logic             dsp_ceopmode,
   output logic             dsp_rst,
   input  logic [47:0]      dsp_p,
   input  logic             dsp_carryout
);

   import dsp_mac_pkg::*;

   state_t             r_state;
   logic [LEN_W-1:0]   r_rem;
   logic               r_first;
   logic [47:0]        r_result;
   logic               r_carry;
   logic               r_pupd;
   logic               w_beat;
   logic [DSP_LAT-1:0] w_v;
   logic               w_f1;
   logic               w_busy;

   // Outputs are gated by RST so they read as reset values from the first
   // cycle RST is seen, before the state registers have been cleared.
   assign s_ready = (r_state == ST_ACCUM) && !RST;
   assign w_beat  = s_ready && s_valid;
   assign w_busy  = |w_v[DSP_LAT-1:1];

   dsp_mac_vpipe #(
      .DEPTH   (DSP_LAT)
   ) u_vpipe (
      .clk     (CLK),
      .rst     (RST),
      .i_vld   (w_beat),
      .i_first (r_first),
      .o_vld   (w_v),
      .o_first (w_f1)
   );

   assign dsp_a        = w_beat ? s_a : 18'd0;
   assign dsp_b        = w_beat ? s_b : 18'd0;
   assign dsp_cea      = w_v[0];
   assign dsp_ceb      = w_v[0];
   assign dsp_cem      = w_v[1] && !RST;
   assign dsp_ceopmode = w_v[1] && !RST;
   assign dsp_cep      = w_v[DSP_LAT-1] && !RST;
   assign dsp_opmode   = (w_v[1] && !RST) ? (w_f1 ? OPM_FIRST : OPM_ACC) : 8'h00;
   assign dsp_c        = 48'd0;
   assign dsp_d        = 18'd0;
   assign dsp_carryin  = 1'b0;
   assign dsp_rst      = RST;

   assign m_valid  = (r_state == ST_DONE) && !RST;
   assign m_result = RST ? 48'd0 : r_result;
   assign m_carry  = r_carry && !RST;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state  <= ST_IDLE;
         r_rem    <= '0;
         r_first  <= 1'b0;
         r_result <= 48'd0;
         r_carry  <= 1'b0;
         r_pupd   <= 1'b0;
      end else begin
         // CARRYOUT is valid the cycle after each P register update
         r_pupd <= w_v[DSP_LAT-1];
         if (r_pupd) begin
            r_carry <= r_carry | dsp_carryout;
         end
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_carry <= 1'b0;
                  if (len != '0) begin
                     r_rem   <= len;
                     r_first <= 1'b1;
                     r_state <= ST_ACCUM;
                  end else begin
                     r_result <= 48'd0;
                     r_state  <= ST_DONE;
                  end
               end
            end
            ST_ACCUM: begin
               if (w_beat) begin
                  r_rem   <= r_rem - LEN_W'(1);
                  r_first <= 1'b0;
                  if (r_rem == LEN_W'(1)) begin
                     r_state <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (!w_busy) begin
                  r_result <= dsp_p;
                  r_state  <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (m_ready) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule : dsp48a1_mac_ctrl
`default_nettype wire

// File: tb/tb_dsp48a1_mac_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dsp48a1_mac_ctrl
// Description : Directed bench for dsp48a1_mac_ctrl with a behavioural
//               DSP48A1 (A1/B1/M/P/OPMODE registers, sync reset).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dsp48a1_mac_ctrl;

   localparam int LEN_W = 8;

   logic              CLK = 1'b0;
   logic              RST = 1'b1;
   logic              start = 1'b0;
   logic [LEN_W-1:0]  len = '0;
   logic              s_valid = 1'b0;
   logic              s_ready;
   logic [17:0]       s_a = '0;
   logic [17:0]       s_b = '0;
   logic              m_valid;
   logic              m_ready = 1'b0;
   logic [47:0]       m_result;
   logic              m_carry;
   logic [17:0]       dsp_a, dsp_b, dsp_d;
   logic [47:0]       dsp_c;
   logic              dsp_carryin;
   logic [7:0]        dsp_opmode;
   logic              dsp_cea, dsp_ceb, dsp_cem, dsp_cep, dsp_ceopmode, dsp_rst;
   logic [47:0]       dsp_p;
   logic              dsp_carryout;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 CLK = ~CLK;

   dsp48a1_mac_ctrl #(
      .LEN_W        (LEN_W),
      .DSP_LAT      (3)
   ) dut (
      .CLK          (CLK),
      .RST          (RST),
      .start        (start),
      .len          (len),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_a          (s_a),
      .s_b          (s_b),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_result     (m_result),
      .m_carry      (m_carry),
      .dsp_a        (dsp_a),
      .dsp_b        (dsp_b),
      .dsp_c        (dsp_c),
      .dsp_d        (dsp_d),
      .dsp_carryin  (dsp_carryin),
      .dsp_opmode   (dsp_opmode),
      .dsp_cea      (dsp_cea),
      .dsp_ceb      (dsp_ceb),
      .dsp_cem      (dsp_cem),
      .dsp_cep      (dsp_cep),
      .dsp_ceopmode (dsp_ceopmode),
      .dsp_rst      (dsp_rst),
      .dsp_p        (dsp_p),
      .dsp_carryout (dsp_carryout)
   );

   // Behavioural DSP48A1: A1REG/B1REG/MREG/PREG/OPMODEREG, X=M, Z=0 or P
   logic signed [17:0] m_a1, m_b1;
   logic signed [47:0] m_m;
   logic [7:0]         m_opm;
   logic [47:0]        m_x, m_z;

   always_comb begin
      m_x = (m_opm[1:0] == 2'b01) ? m_m   : 48'd0;
      m_z = (m_opm[3:2] == 2'b10) ? dsp_p : 48'd0;
   end

   always_ff @(posedge CLK) begin
      if (dsp_rst) begin
         m_a1         <= '0;
         m_b1         <= '0;
         m_m          <= '0;
         m_opm        <= '0;
         dsp_p        <= '0;
         dsp_carryout <= 1'b0;
      end else begin
         if (dsp_cea)      m_a1  <= dsp_a;
         if (dsp_ceb)      m_b1  <= dsp_b;
         if (dsp_cem)      m_m   <= m_a1 * m_b1;
         if (dsp_ceopmode) m_opm <= dsp_opmode;
         if (dsp_cep)      {dsp_carryout, dsp_p} <= {1'b0, m_z} + {1'b0, m_x};
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic smp();
      @(negedge CLK);
   endtask

   task automatic start_run(input logic [LEN_W-1:0] n);
      start = 1'b1;
      len   = n;
      step();
      start = 1'b0;
      len   = '0;
   endtask

   task automatic beat(input logic [17:0] a, input logic [17:0] b);
      s_valid = 1'b1;
      s_a     = a;
      s_b     = b;
      smp();
      chk("beat_ready_ce", {61'd0, s_ready, dsp_cea, dsp_ceb}, 64'b111);
      chk("beat_dsp_ab", {28'd0, dsp_a, dsp_b}, {28'd0, a, b});
      step();
      s_valid = 1'b0;
      s_a     = '0;
      s_b     = '0;
   endtask

   task automatic wait_done(input string tag, input int max_cyc);
      int cyc;
      cyc = 0;
      smp();
      while (!m_valid && cyc < max_cyc) begin
         step();
         smp();
         cyc++;
      end
      chk(tag, {63'd0, m_valid}, 64'd1);
   endtask

   task automatic finish_run(input string tag);
      m_ready = 1'b1;
      step();
      m_ready = 1'b0;
      smp();
      chk(tag, {63'd0, m_valid}, 64'd0);
   endtask

   task automatic chk_reset_outs(input string tag);
      chk({tag, "_ctrl"}, {56'd0, s_ready, m_valid, dsp_cea, dsp_ceb, dsp_cem,
                           dsp_cep, dsp_ceopmode, dsp_rst}, 64'b0000_0001);
      chk({tag, "_res"}, {15'd0, m_carry, m_result}, 64'd0);
      chk({tag, "_dsp"}, {20'd0, dsp_a, dsp_b, dsp_opmode}, 64'd0);
   endtask

   initial begin
      // Power-on reset
      RST = 1'b1;
      step();
      step();
      smp();
      chk_reset_outs("por");
      chk("const_cd_cin", {dsp_c, dsp_d[15:0]} | {63'd0, dsp_carryin}, 64'd0);
      RST = 1'b0;
      step();
      smp();
      chk("por_rst_low", {63'd0, dsp_rst}, 64'd0);

      // len=1 latency: start at cycle 0, beat at cycle 1, m_valid at cycle 5
      start_run(8'd1);
      beat(18'sd3, 18'sd4);
      step();
      step();
      smp();
      chk("t1_not_early", {63'd0, m_valid}, 64'd0);
      step();
      smp();
      chk("t1_valid_c5", {63'd0, m_valid}, 64'd1);
      chk("t1_result", {16'd0, m_result}, 64'd12);
      chk("t1_carry", {63'd0, m_carry}, 64'd0);
      finish_run("t1_ack");

      // len=4 mixed signs: 2-15+49+1 = 37; -13+49 carries out of bit 47
      start_run(8'd4);
      beat(18'sd1, 18'sd2);
      beat(-18'sd3, 18'sd5);
      beat(18'sd7, 18'sd7);
      beat(-18'sd1, -18'sd1);
      wait_done("t2_done", 20);
      chk("t2_result", {16'd0, m_result}, 64'd37);
      chk("t2_carry", {63'd0, m_carry}, 64'd1);
      finish_run("t2_ack");

      // len=0: immediate zero result, held while m_ready low, start ignored
      start_run(8'd0);
      smp();
      chk("t4_valid", {63'd0, m_valid}, 64'd1);
      chk("t4_res", {15'd0, m_carry, m_result}, 64'd0);
      for (int i = 0; i < 5; i++) begin
         if (i == 2) begin
            start = 1'b1;
            len   = 8'd5;
         end
         step();
         start = 1'b0;
         len   = '0;
         smp();
         chk("t4_hold", {14'd0, m_valid, m_carry, m_result}, {14'd0, 2'b10, 48'd0});
      end
      finish_run("t4_ack");
      step();
      smp();
      chk("t4_start_ignored", {62'd0, s_ready, m_valid}, 64'd0);

      // len=3 with two bubble cycles between beats: 3 * 10000
      start_run(8'd3);
      for (int i = 0; i < 3; i++) begin
         beat(18'sd100, 18'sd100);
         if (i < 2) begin
            for (int j = 0; j < 2; j++) begin
               smp();
               chk("t3_bubble", {61'd0, s_ready, dsp_cea, dsp_ceb}, 64'b100);
               step();
            end
         end
      end
      wait_done("t3_done", 20);
      chk("t3_result", {16'd0, m_result}, 64'd30000);
      chk("t3_carry", {63'd0, m_carry}, 64'd0);
      finish_run("t3_ack");

      // Reset after 2 of 4 beats, operands still offered during reset
      start_run(8'd4);
      beat(18'sd5, 18'sd6);
      beat(18'sd7, 18'sd8);
      RST     = 1'b1;
      s_valid = 1'b1;
      s_a     = 18'sd9;
      s_b     = 18'sd9;
      smp();
      chk_reset_outs("t5_rst0");
      step();
      smp();
      chk_reset_outs("t5_rst1");
      RST     = 1'b0;
      s_valid = 1'b0;
      s_a     = '0;
      s_b     = '0;
      step();
      smp();
      chk("t5_rst_low", {63'd0, dsp_rst}, 64'd0);
      for (int i = 0; i < 8; i++) begin
         step();
         smp();
         chk("t5_abandoned", {62'd0, m_valid, s_ready}, 64'd0);
      end
      start_run(8'd1);
      beat(18'sd2, -18'sd2);
      wait_done("t5_done", 20);
      chk("t5_result", {16'd0, m_result}, {16'd0, 48'hFFFF_FFFF_FFFC});
      chk("t5_carry", {63'd0, m_carry}, 64'd0);
      finish_run("t5_ack");

      // Most negative operands: 2 * 2^34 = 2^35
      start_run(8'd2);
      beat(18'h20000, 18'h20000);
      beat(18'h20000, 18'h20000);
      wait_done("t6_done", 20);
      chk("t6_result", {16'd0, m_result}, {16'd0, 48'h8_0000_0000});
      chk("t6_carry", {63'd0, m_carry}, 64'd0);
      finish_run("t6_ack");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_dsp48a1_mac_ctrl
`default_nettype wire

// File: doc/dsp48a1_mac_ctrl.md
DSP48A1_MAC_CTRL -- requirements
Module: dsp48a1_mac_ctrl

Interface
REQ-001 Parameter LEN_W, default 8, width of the term-count input.
REQ-002 Parameter DSP_LAT, default 3, cycles from operands driven to P updated (A1REG=1, B1REG=1, MREG=1, PREG=1, OPMODEREG=1, A0REG=B0REG=0, RSTTYPE="SYNC", B_INPUT="DIRECT").
REQ-003 CLK  in  1  sole clock; all logic SHALL be rising-edge on CLK.
REQ-004 RST  in  1  reset; synchronous and active-high.
REQ-005 start  in  1  one-cycle pulse that begins a dot product; sampled only in IDLE.
REQ-006 len  in  LEN_W  number of terms, latched on accepted start.
REQ-007 s_valid / s_ready  in / out  1  operand handshake; a beat transfers when both are high.
REQ-008 s_a, s_b  in  18 each  signed operand pair.
REQ-009 m_valid / m_ready  out / in  1  result handshake.
REQ-010 m_result  out  48  accumulated sum; m_carry  out  1  sticky OR of dsp_carryout over the run.
REQ-011 dsp_a, dsp_b  out  18 each  to DSP48A1 A/B; dsp_c out 48 and dsp_d out 18 SHALL be constant 0; dsp_carryin out 1 constant 0.
REQ-012 dsp_opmode  out  8; dsp_cea, dsp_ceb, dsp_cem, dsp_cep, dsp_ceopmode  out  1 each.
REQ-013 dsp_rst  out  1  drives all DSP RSTA..RSTP/RSTOPMODE/RSTCARRYIN.
REQ-014 dsp_p  in  48; dsp_carryout  in  1  from DSP48A1 P/CARRYOUT.

Function
REQ-015 FSM states SHALL be IDLE, ACCUM, DRAIN, DONE.
REQ-016 IDLE: s_ready=0; on start with len!=0 latch len, clear m_carry, go ACCUM; on start with len==0 go DONE with m_result=0, m_carry=0.
REQ-017 ACCUM: s_ready=1; each accepted beat drives dsp_a=s_a, dsp_b=s_b, dsp_cea=dsp_ceb=1 that cycle, decrements remaining count; the beat that brings remaining to 0 moves to DRAIN.
REQ-018 Bubbles (s_valid=0 in ACCUM) SHALL drive cea=ceb=0 and SHALL NOT change any DSP register.
REQ-019 A 3-bit valid pipe and 1-bit first-term pipe SHALL track beats: stage0 = beat cycle, stage1 = +1, stage2 = +2.
REQ-020 dsp_cem SHALL equal stage1 valid; dsp_cep SHALL equal stage2 valid; dsp_ceopmode SHALL equal stage1 valid.
REQ-021 dsp_opmode SHALL be driven in stage1 cycle: 8'h01 (Z=0, X=M) for the first term, 8'h09 (Z=P, X=M) for later terms; pre-adder and subtract bits 0.
REQ-022 m_carry SHALL OR in dsp_carryout on the cycle after each P update.
REQ-023 DRAIN: s_ready=0; when the valid pipe is empty and one further cycle elapsed, capture dsp_p into m_result and go DONE.
REQ-024 DONE: m_valid=1, m_result and m_carry stable; on m_ready go IDLE; start ignored.
REQ-025 start outside IDLE SHALL be ignored.
REQ-026 Result SHALL equal sum of s_a*s_b (signed, 36-bit products sign-extended) modulo 2^48.
REQ-027 Minimum latency: len=1, no bubbles, start at cycle 0, beat at cycle 1 -> m_valid at cycle 1+DSP_LAT+1 = 5.

Reset
REQ-028 While RST=1: state IDLE, s_ready=0, m_valid=0, m_result=0, m_carry=0, all CE outputs 0, dsp_opmode=0, dsp_a=dsp_b=0, pipes cleared, dsp_rst=1.
REQ-029 dsp_rst SHALL be 0 whenever RST=0.
REQ-030 RST mid-ACCUM/DRAIN/DONE SHALL abandon the run; no m_valid SHALL follow.

Structure
REQ-031 Package dsp_mac_pkg SHALL hold the state enum, OPM_FIRST=8'h01, OPM_ACC=8'h09, DSP_LAT.
REQ-032 Valid/first-term delay SHALL be sub-module dsp_mac_vpipe; the DSP48A1 itself SHALL NOT be instantiated inside this block.

Verification (bench instantiates DSP48A1 with REQ-002 parameters)
REQ-033 len=1, (3,4) -> m_result=12 at cycle 5, m_carry=0.
REQ-034 len=4, (1,2),(-3,5),(7,7),(-1,-1) -> m_result=48'd37 (2-15+49+1).
REQ-035 len=3 with s_valid low 2 cycles between beats, (100,100)x3 -> 30000; no CE pulses in bubble cycles.
REQ-036 len=0 -> m_valid next cycle, m_result=0; m_ready low 5 cycles -> result held, second start ignored.
REQ-037 RST pulsed after 2 of 4 beats -> all outputs at reset values; fresh len=1 (2,-2) run -> -4 (48'hFFFF_FFFF_FFFC).
REQ-038 len=2, (-131072,-131072)x2 -> 2^35 = 48'h8_0000_0000.
